idct_odd: RTL and testbench

Inverse-transform counterpart of the forward odd-coefficient stage. It accepts the four odd-index DCT coefficients of one 8-point row (y1, y3, y5, y7) and produces the four odd-part reconstruction terms o0..o3 of the 8-point IDCT. The even-part block and the output butterfly combine them downstream (x[k] = e[k] + o[k], x[7-k] = e[k] − o[k]). It sits between the coefficient buffer and the IDCT butterfly, time-multiplexing one bank of four multipliers over four cycles with a valid/ready handshake on both sides.

---
 rtl/dct_pkg.sv | 30 +++
 rtl/idct_odd_if.sv | 28 ++
 rtl/idct_scale_sat.sv | 27 ++
 rtl/idct_odd.sv | 148 ++++++++++++++
 tb/tb_idct_odd.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT/IDCT datapath stages.
// Widths, the FSM state type and the 24-bit saturation helper live here.
package dct_pkg;

   localparam int DATA_W = 24;
   localparam int COEF_W = 16;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = 42;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 42'sd8388607;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -42'sd8388608;

   function automatic logic signed [DATA_W-1:0] sat24(input logic signed [ACC_W-1:0] v);
      logic signed [DATA_W-1:0] r;
      if (v > SAT_MAX)
         r = SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN)
         r = SAT_MIN[DATA_W-1:0];
      else
         r = v[DATA_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/idct_odd_if.sv
// Coefficient-in / odd-terms-out handshake bundle for idct_odd.
interface idct_odd_if;
   import dct_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] y1;
   logic signed [DATA_W-1:0] y3;
   logic signed [DATA_W-1:0] y5;
   logic signed [DATA_W-1:0] y7;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] o0;
   logic signed [DATA_W-1:0] o1;
   logic signed [DATA_W-1:0] o2;
   logic signed [DATA_W-1:0] o3;

   modport master (
      output in_valid, y1, y3, y5, y7, out_ready,
      input  in_ready, out_valid, o0, o1, o2, o3
   );

   modport slave (
      input  in_valid, y1, y3, y5, y7, out_ready,
      output in_ready, out_valid, o0, o1, o2, o3
   );

endinterface

// File: rtl/idct_scale_sat.sv
// Signed truncate-toward-zero division of an accumulated row sum by CU,
// followed by clamping to the 24-bit output range.
module idct_scale_sat
   import dct_pkg::*;
#(
   parameter int CU = 256
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] res
);

   logic                    neg;
   logic [ACC_W-1:0]        mag;
   logic [ACC_W-1:0]        quo;
   logic signed [ACC_W-1:0] quo_signed;

   // Dividing the magnitude keeps rounding toward zero for negative sums.
   always_comb begin
      neg        = acc[ACC_W-1];
      mag        = neg ? ACC_W'(-acc) : ACC_W'(acc);
      quo        = mag / ACC_W'(CU);
      quo_signed = neg ? -$signed(quo) : $signed(quo);
   end

   assign res = sat24(quo_signed);

endmodule

// File: rtl/idct_odd.sv
// Odd half of the 8-point IDCT: one bank of four multipliers is reused over
// four cycles to produce o0..o3 from y1, y3, y5, y7.
module idct_odd
   import dct_pkg::*;
#(
   parameter int C1 = 251,
   parameter int C3 = 213,
   parameter int C5 = 142,
   parameter int C7 = 50,
   parameter int CU = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   idct_odd_if.slave  bus
);

   state_t state;
   state_t state_next;
   logic [1:0] row;
   logic       accept;
   logic       ready_int;
   logic       valid_int;

   logic signed [DATA_W-1:0] y1_q;
   logic signed [DATA_W-1:0] y3_q;
   logic signed [DATA_W-1:0] y5_q;
   logic signed [DATA_W-1:0] y7_q;
   logic signed [DATA_W-1:0] o_reg [4];

   logic signed [COEF_W-1:0] k1;
   logic signed [COEF_W-1:0] k3;
   logic signed [COEF_W-1:0] k5;
   logic signed [COEF_W-1:0] k7;
   logic signed [PROD_W-1:0] p1;
   logic signed [PROD_W-1:0] p3;
   logic signed [PROD_W-1:0] p5;
   logic signed [PROD_W-1:0] p7;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] scaled;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A HOLD that is drained while a new row is offered restarts CALC directly.
   always_comb begin
      state_next = state;
      ready_int  = 1'b0;
      valid_int  = 1'b0;
      case (state)
         IDLE: begin
            ready_int = rst_n;
            if (bus.in_valid)
               state_next = CALC;
         end
         CALC: begin
            if (row == 2'd3)
               state_next = HOLD;
         end
         HOLD: begin
            valid_int = 1'b1;
            if (bus.out_ready) begin
               ready_int  = rst_n;
               state_next = bus.in_valid ? CALC : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      accept = bus.in_valid && ready_int;
   end

   // Per-row sign/constant permutation of the cosine table.
   always_comb begin
      k1 = COEF_W'(C1);
      k3 = COEF_W'(C3);
      k5 = COEF_W'(C5);
      k7 = COEF_W'(C7);
      case (row)
         2'd1: begin
            k1 = COEF_W'(C3);
            k3 = COEF_W'(-C7);
            k5 = COEF_W'(-C1);
            k7 = COEF_W'(-C5);
         end
         2'd2: begin
            k1 = COEF_W'(C5);
            k3 = COEF_W'(-C1);
            k5 = COEF_W'(C7);
            k7 = COEF_W'(C3);
         end
         2'd3: begin
            k1 = COEF_W'(C7);
            k3 = COEF_W'(-C5);
            k5 = COEF_W'(C3);
            k7 = COEF_W'(-C1);
         end
         default: ;
      endcase
   end

   always_comb begin
      p1  = PROD_W'(y1_q) * PROD_W'(k1);
      p3  = PROD_W'(y3_q) * PROD_W'(k3);
      p5  = PROD_W'(y5_q) * PROD_W'(k5);
      p7  = PROD_W'(y7_q) * PROD_W'(k7);
      acc = ACC_W'(p1) + ACC_W'(p3) + ACC_W'(p5) + ACC_W'(p7);
   end

   idct_scale_sat #(.CU(CU)) u_scale (
      .acc (acc),
      .res (scaled)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row  <= 2'd0;
         y1_q <= '0;
         y3_q <= '0;
         y5_q <= '0;
         y7_q <= '0;
         for (int i = 0; i < 4; i++)
            o_reg[i] <= '0;
      end else begin
         if (accept) begin
            y1_q <= bus.y1;
            y3_q <= bus.y3;
            y5_q <= bus.y5;
            y7_q <= bus.y7;
            row  <= 2'd0;
         end
         if (state == CALC) begin
            o_reg[row] <= scaled;
            row        <= (row == 2'd3) ? 2'd0 : row + 2'd1;
         end
      end
   end

   assign bus.in_ready  = ready_int;
   assign bus.out_valid = valid_int;
   assign bus.o0        = o_reg[0];
   assign bus.o1        = o_reg[1];
   assign bus.o2        = o_reg[2];
   assign bus.o3        = o_reg[3];

endmodule

// File: tb/tb_idct_odd.sv
// Scoreboard bench for idct_odd: directed rows from the test plan plus
// random rows checked against an arithmetic model of the odd IDCT equations.
module tb_idct_odd;

   localparam longint K1 = 251;
   localparam longint K3 = 213;
   localparam longint K5 = 142;
   localparam longint K7 = 50;
   localparam longint KU = 256;

   typedef struct {
      longint o[4];
      int     acc_edge;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_err;
   bit   prev_valid;
   bit   rand_rdy;
   longint snap [4];
   exp_t sb [$];

   idct_odd_if bus ();

   idct_odd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint clamp24(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   // Plain equations; SV integer division already truncates toward zero.
   function automatic exp_t model(input int a, input int b, input int c, input int d);
      exp_t   e;
      longint p [4];
      p[0] = K1*a + K3*b + K5*c + K7*d;
      p[1] = K3*a - K7*b - K1*c - K5*d;
      p[2] = K5*a - K1*b + K7*c + K3*d;
      p[3] = K7*a - K5*b + K3*c - K1*d;
      for (int i = 0; i < 4; i++)
         e.o[i] = clamp24(p[i] / KU);
      e.acc_edge = 0;
      return e;
   endfunction

   function automatic int rand_y();
      logic signed [23:0] r;
      r = 24'($urandom);
      return int'(r) >>> $urandom_range(0, 16);
   endfunction

   // Offer one row; the expected result is queued at the accepting edge.
   task automatic send_row(input int a, input int b, input int c, input int d,
                           input bit use_model, input longint e0, input longint e1,
                           input longint e2, input longint e3, output int waited);
      exp_t e;
      bus.y1 = 24'(a);
      bus.y3 = 24'(b);
      bus.y5 = 24'(c);
      bus.y7 = 24'(d);
      bus.in_valid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waited++;
         if (waited > 300) break;
      end
      if (waited > 300) begin
         check("accept_timeout", 0, 1);
      end else begin
         if (use_model)
            e = model(a, b, c, d);
         else begin
            e.o[0] = e0;
            e.o[1] = e1;
            e.o[2] = e2;
            e.o[3] = e3;
         end
         e.acc_edge = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.y1 = 24'($urandom);
      bus.y3 = 24'($urandom);
      bus.y5 = 24'($urandom);
      bus.y7 = 24'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0)
         check("drain_timeout", longint'(sb.size()), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               if (!prev_valid)
                  check("latency", longint'(cyc - sb[0].acc_edge), 4);
               else begin
                  check("hold_o0", longint'(bus.o0), snap[0]);
                  check("hold_o3", longint'(bus.o3), snap[3]);
               end
               if (!bus.out_ready)
                  check("in_ready_in_hold", longint'(bus.in_ready), 0);
               else begin
                  e = sb.pop_front();
                  check("o0", longint'(bus.o0), e.o[0]);
                  check("o1", longint'(bus.o1), e.o[1]);
                  check("o2", longint'(bus.o2), e.o[2]);
                  check("o3", longint'(bus.o3), e.o[3]);
               end
            end
            snap[0] = longint'(bus.o0);
            snap[1] = longint'(bus.o1);
            snap[2] = longint'(bus.o2);
            snap[3] = longint'(bus.o3);
         end
         prev_valid = bus.out_valid;
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      check({tag, "_o0"}, longint'(bus.o0), 0);
      check({tag, "_o1"}, longint'(bus.o1), 0);
      check({tag, "_o2"}, longint'(bus.o2), 0);
      check({tag, "_o3"}, longint'(bus.o3), 0);
   endtask

   initial begin
      int w;
      cyc = 0;
      n_cmp = 0;
      n_err = 0;
      prev_valid = 1'b0;
      rand_rdy = 1'b0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.y1 = '0;
      bus.y3 = '0;
      bus.y5 = '0;
      bus.y7 = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      send_row(256, 0, 0, 0, 1'b0, 251, 213, 142, 50, w);
      drain();
      send_row(-256, 0, 0, 0, 1'b0, -251, -213, -142, -50, w);
      drain();
      send_row(-3, 0, 0, 0, 1'b0, -2, -2, -1, 0, w);
      drain();
      send_row(0, 256, 0, 0, 1'b0, 213, -50, -251, -142, w);
      drain();
      send_row(8388607, 8388607, 8388607, 8388607, 1'b0,
               8388607, -7536639, 5046271, -4259839, w);
      drain();

      // Backpressure, then release with a new row offered in the same cycle.
      bus.out_ready = 1'b0;
      send_row(1000, -2000, 3000, -4000, 1'b1, 0, 0, 0, 0, w);
      w = 0;
      while (!bus.out_valid && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("bp_reached_hold", longint'(bus.out_valid), 1);
      repeat (10) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send_row(-77777, 12345, 654321, -1, 1'b1, 0, 0, 0, 0, w);
      check("b2b_accept_same_cycle", longint'(w), 0);
      drain();

      // Reset while row 2 is being computed.
      send_row(256, 0, 0, 0, 1'b0, 251, 213, 142, 50, w);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset_in_ready", longint'(bus.in_ready), 1);
      repeat (10) @(posedge clk);
      #1;

      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send_row(rand_y(), rand_y(), rand_y(), rand_y(), 1'b1, 0, 0, 0, 0, w);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      drain();
      repeat (5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
